// File: rtl/instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// common_def : shared RV32I encoding definitions.
//   instruction_type : decoded instruction kinds accepted by instr_encoder.
//   *_opcode         : 7-bit major opcodes.
//   F3_*             : funct3 values for LOAD/STORE.
//   FUNCT7_ALT       : funct7 for SUB/SRA/SRAI.
//   NOP_INSTR_HEX / ECALL_INSTR_HEX : fixed instruction words.
// ---------------------------------------------------------------------------
package common_def;

    typedef enum logic [5:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
        SLLI, SRLI, SRAI,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LUI, AUIPC, JAL, JALR,
        NOP, ECALL, INVALID
    } instruction_type;

    localparam logic [6:0] OP_opcode     = 7'b0110011;
    localparam logic [6:0] OP_IMM_opcode = 7'b0010011;
    localparam logic [6:0] LOAD_opcode   = 7'b0000011;
    localparam logic [6:0] STORE_opcode  = 7'b0100011;
    localparam logic [6:0] BRANCH_opcode = 7'b1100011;
    localparam logic [6:0] JALR_opcode   = 7'b1100111;
    localparam logic [6:0] JAL_opcode    = 7'b1101111;
    localparam logic [6:0] LUI_opcode    = 7'b0110111;
    localparam logic [6:0] AUIPC_opcode  = 7'b0010111;
    localparam logic [6:0] SYSTEM_opcode = 7'b1110011;

    // LOAD / STORE funct3 table
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [6:0]  FUNCT7_ALT      = 7'b0100000;
    localparam logic [31:0] NOP_INSTR_HEX   = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR_HEX = 32'h0000_0073;

endpackage

// File: rtl/instr_encoder_core.sv
// ---------------------------------------------------------------------------
// instr_enc_core : purely combinational RV32I encoder.
//   in_type         : instruction kind
//   rd, rs1, rs2    : register indices
//   imm             : signed byte-offset immediate (full value for U-type)
//   word            : encoded 32-bit instruction
//   is_invalid      : in_type is INVALID (word is don't-care)
//   range_err       : immediate out of range (only with INSTR_ENC_RANGE_CHK_EN;
//                     word is then replaced by NOP_INSTR_HEX)
// Macro: INSTR_ENC_RANGE_CHK_EN enables the immediate range check; otherwise
// immediates are truncated to their field and range_err is 0.
// ---------------------------------------------------------------------------
import common_def::*;

module instr_enc_core (
    input  instruction_type in_type,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [31:0]     imm,
    output logic [31:0]     word,
    output logic            is_invalid,
    output logic            range_err
);

    logic [31:0] raw_word;

    always_comb begin
        raw_word   = NOP_INSTR_HEX;
        is_invalid = 1'b0;
        unique case (in_type)
            ADD:   raw_word = {7'b0,       rs2, rs1, 3'b000, rd, OP_opcode};
            SUB:   raw_word = {FUNCT7_ALT, rs2, rs1, 3'b000, rd, OP_opcode};
            SLL:   raw_word = {7'b0,       rs2, rs1, 3'b001, rd, OP_opcode};
            SLT:   raw_word = {7'b0,       rs2, rs1, 3'b010, rd, OP_opcode};
            SLTU:  raw_word = {7'b0,       rs2, rs1, 3'b011, rd, OP_opcode};
            XOR:   raw_word = {7'b0,       rs2, rs1, 3'b100, rd, OP_opcode};
            SRL:   raw_word = {7'b0,       rs2, rs1, 3'b101, rd, OP_opcode};
            SRA:   raw_word = {FUNCT7_ALT, rs2, rs1, 3'b101, rd, OP_opcode};
            OR:    raw_word = {7'b0,       rs2, rs1, 3'b110, rd, OP_opcode};
            AND:   raw_word = {7'b0,       rs2, rs1, 3'b111, rd, OP_opcode};
            ADDI:  raw_word = {imm[11:0], rs1, 3'b000, rd, OP_IMM_opcode};
            SLTI:  raw_word = {imm[11:0], rs1, 3'b010, rd, OP_IMM_opcode};
            SLTIU: raw_word = {imm[11:0], rs1, 3'b011, rd, OP_IMM_opcode};
            XORI:  raw_word = {imm[11:0], rs1, 3'b100, rd, OP_IMM_opcode};
            ORI:   raw_word = {imm[11:0], rs1, 3'b110, rd, OP_IMM_opcode};
            ANDI:  raw_word = {imm[11:0], rs1, 3'b111, rd, OP_IMM_opcode};
            SLLI:  raw_word = {7'b0,       imm[4:0], rs1, 3'b001, rd, OP_IMM_opcode};
            SRLI:  raw_word = {7'b0,       imm[4:0], rs1, 3'b101, rd, OP_IMM_opcode};
            SRAI:  raw_word = {FUNCT7_ALT, imm[4:0], rs1, 3'b101, rd, OP_IMM_opcode};
            LB:    raw_word = {imm[11:0], rs1, F3_LB,  rd, LOAD_opcode};
            LH:    raw_word = {imm[11:0], rs1, F3_LH,  rd, LOAD_opcode};
            LW:    raw_word = {imm[11:0], rs1, F3_LW,  rd, LOAD_opcode};
            LBU:   raw_word = {imm[11:0], rs1, F3_LBU, rd, LOAD_opcode};
            LHU:   raw_word = {imm[11:0], rs1, F3_LHU, rd, LOAD_opcode};
            SB:    raw_word = {imm[11:5], rs2, rs1, F3_SB, imm[4:0], STORE_opcode};
            SH:    raw_word = {imm[11:5], rs2, rs1, F3_SH, imm[4:0], STORE_opcode};
            SW:    raw_word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], STORE_opcode};
            BEQ:   raw_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], BRANCH_opcode};
            BNE:   raw_word = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], BRANCH_opcode};
            BLT:   raw_word = {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], BRANCH_opcode};
            BGE:   raw_word = {imm[12], imm[10:5], rs2, rs1, 3'b101, imm[4:1], imm[11], BRANCH_opcode};
            BLTU:  raw_word = {imm[12], imm[10:5], rs2, rs1, 3'b110, imm[4:1], imm[11], BRANCH_opcode};
            BGEU:  raw_word = {imm[12], imm[10:5], rs2, rs1, 3'b111, imm[4:1], imm[11], BRANCH_opcode};
            LUI:   raw_word = {imm[31:12], rd, LUI_opcode};
            AUIPC: raw_word = {imm[31:12], rd, AUIPC_opcode};
            JAL:   raw_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL_opcode};
            JALR:  raw_word = {imm[11:0], rs1, 3'b000, rd, JALR_opcode};
            NOP:   raw_word = NOP_INSTR_HEX;
            ECALL: raw_word = ECALL_INSTR_HEX;
            default: begin
                raw_word   = NOP_INSTR_HEX;
                is_invalid = 1'b1;
            end
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHK_EN
    // Sign-extension checks: a value fits an N-bit signed field when all
    // bits above the field's sign bit equal that sign bit.
    logic fits_i, fits_b, fits_j, fits_u, fits_sh, bad;

    always_comb begin
        fits_i  = (&imm[31:11]) || !(|imm[31:11]);
        fits_b  = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
        fits_j  = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
        fits_u  = !(|imm[11:0]);
        fits_sh = !(|imm[31:5]);
        unique case (in_type)
            ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
            LB, LH, LW, LBU, LHU, SB, SH, SW, JALR: bad = !fits_i;
            SLLI, SRLI, SRAI:                      bad = !fits_sh;
            BEQ, BNE, BLT, BGE, BLTU, BGEU:        bad = !fits_b;
            LUI, AUIPC:                            bad = !fits_u;
            JAL:                                   bad = !fits_j;
            default:                               bad = 1'b0;
        endcase
        range_err = bad;
        word      = bad ? NOP_INSTR_HEX : raw_word;
    end
`else
    assign range_err = 1'b0;
    assign word      = raw_word;
`endif

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder : streaming RV32I encoder / loader with a 2-entry output FIFO.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous clear of FIFO, address and word count
//   in_valid/in_ready : descriptor handshake (in_ready = FIFO not full)
//   in_type, in_rd, in_rs1, in_rs2, in_imm : descriptor fields
//   out_valid/out_ready : word handshake
//   out_word, out_addr  : FIFO head word and its memory address
//   word_count        : words emitted since reset/flush, saturating
//   err_invalid       : pulse the cycle after an INVALID is accepted
//   err_range         : pulse the cycle after an out-of-range immediate
// Macro: INSTR_ENC_RANGE_CHK_EN enables immediate range checking
// (in instr_enc_core); without it err_range stays 0.
// ---------------------------------------------------------------------------
import common_def::*;

module instr_encoder #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  instruction_type   in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       word_count,
    output logic              err_invalid,
    output logic              err_range
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    logic [31:0]       enc_word;
    logic              enc_invalid;
    logic              enc_range_err;

    logic [31:0]       mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wcount_q;
    logic              err_invalid_q;
    logic              err_range_q;

    logic              accept;
    logic              push;
    logic              pop;

    instr_enc_core u_core (
        .in_type    (in_type),
        .rd         (in_rd),
        .rs1        (in_rs1),
        .rs2        (in_rs2),
        .imm        (in_imm),
        .word       (enc_word),
        .is_invalid (enc_invalid),
        .range_err  (enc_range_err)
    );

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    // INVALID descriptors are consumed but never enter the FIFO.
    assign push      = accept && !enc_invalid;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= '0;
            addr_q        <= BASE;
            wcount_q      <= '0;
            err_invalid_q <= 1'b0;
            err_range_q   <= 1'b0;
        end else if (flush) begin
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= '0;
            addr_q        <= BASE;
            wcount_q      <= '0;
            err_invalid_q <= 1'b0;
            err_range_q   <= 1'b0;
        end else begin
            err_invalid_q <= accept && enc_invalid;
            err_range_q   <= push && enc_range_err;
            if (push) begin
                mem[wr_ptr] <= enc_word;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
                addr_q <= addr_q + STEP;
                if (wcount_q != 16'hFFFF) wcount_q <= wcount_q + 16'd1;
            end
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

    assign out_word    = mem[rd_ptr];
    assign out_addr    = addr_q;
    assign word_count  = wcount_q;
    assign err_invalid = err_invalid_q;
    assign err_range   = err_range_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder : directed self-checking bench for instr_encoder.
// Instance a: ADDR_W=32, BASE_ADDR=0x100. Instance w: ADDR_W=4, BASE_ADDR=0xC
// (address wrap). Both share all inputs.
// Honours INSTR_ENC_RANGE_CHK_EN for the out-of-range immediate expectations.
// ---------------------------------------------------------------------------
import common_def::*;

module tb_instr_encoder;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    instruction_type in_type;
    logic [4:0]      in_rd, in_rs1, in_rs2;
    logic [31:0]     in_imm;
    logic            out_ready;

    logic            a_in_ready, a_out_valid, a_err_invalid, a_err_range;
    logic [31:0]     a_out_word, a_out_addr;
    logic [15:0]     a_word_count;

    logic            w_in_ready, w_out_valid, w_err_invalid, w_err_range;
    logic [31:0]     w_out_word;
    logic [3:0]      w_out_addr;
    logic [15:0]     w_word_count;

    int unsigned     checks = 0;
    int unsigned     errors = 0;
    logic [31:0]     exp_addr;
    logic [15:0]     exp_cnt;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0100)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_type(in_type),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_word(a_out_word),
        .out_addr(a_out_addr), .word_count(a_word_count),
        .err_invalid(a_err_invalid), .err_range(a_err_range)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(32'h0000_000C)) u_w (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_type(in_type),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_word(w_out_word),
        .out_addr(w_out_addr), .word_count(w_word_count),
        .err_invalid(w_err_invalid), .err_range(w_err_range)
    );

    typedef struct {
        instruction_type t;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [31:0]     exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input instruction_type t, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        in_valid = 1'b1;
        in_type  = t;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_addr  = exp_addr + 32'd4;
        exp_cnt   = exp_cnt + 16'd1;
    endtask

    initial begin
        vecs[0] = '{LUI,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7};
        vecs[1] = '{BEQ,  5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_8463};
        vecs[2] = '{JAL,  5'd1, 5'd0, 5'd0, 32'd2048,      32'h0010_00EF};
        vecs[3] = '{SW,   5'd0, 5'd1, 5'd2, 32'd4,         32'h0020_A223};
        vecs[4] = '{SRAI, 5'd2, 5'd3, 5'd0, 32'd7,         32'h4071_D113};
        vecs[5] = '{SRA,  5'd3, 5'd1, 5'd2, 32'd0,         32'h4020_D1B3};
        vecs[6] = '{LW,   5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFFC1_2283};
        vecs[7] = '{BNE,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_9EE3};
        vecs[8] = '{NOP,  5'd7, 5'd7, 5'd7, 32'd123,       32'h0000_0013};
        vecs[9] = '{ECALL,5'd7, 5'd7, 5'd7, 32'd123,       32'h0000_0073};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_type = NOP; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        exp_addr = 32'h100;
        exp_cnt  = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
        chk("rst_out_word", a_out_word, 32'd0);
        chk("rst_out_addr", a_out_addr, 32'h100);
        chk("rst_word_count", {16'b0, a_word_count}, 32'd0);
        chk("rst_in_ready", {31'b0, a_in_ready}, 32'd1);
        chk("rst_errs", {30'b0, a_err_invalid, a_err_range}, 32'd0);
        chk("rst_w_addr", {28'b0, w_out_addr}, 32'hC);

        // ADDI, one-cycle latency
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        chk("addi_valid", {31'b0, a_out_valid}, 32'd1);
        chk("addi_word", a_out_word, 32'h0050_0093);
        chk("addi_addr", a_out_addr, exp_addr);
        pop_one();
        chk("addi_count", {16'b0, a_word_count}, {16'b0, exp_cnt});
        chk("addi_drained", {31'b0, a_out_valid}, 32'd0);

        // Back-to-back ADD / SUB with out_ready high
        out_ready = 1'b1;
        drive(ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        drive(SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        chk("add_word", a_out_word, 32'h0020_81B3);
        chk("add_addr", a_out_addr, exp_addr);
        tick();
        in_valid = 1'b0;
        chk("sub_word", a_out_word, 32'h4020_81B3);
        chk("sub_addr", a_out_addr, exp_addr + 32'd4);
        chk("sub_valid", {31'b0, a_out_valid}, 32'd1);
        tick();
        out_ready = 1'b0;
        exp_addr = exp_addr + 32'd8;
        exp_cnt  = exp_cnt + 16'd2;
        chk("addsub_count", {16'b0, a_word_count}, {16'b0, exp_cnt});
        chk("addsub_drained", {31'b0, a_out_valid}, 32'd0);

        // Encoding table
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].t, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'b0, a_out_valid}, 32'd1);
            chk($sformatf("vec%0d_word", i), a_out_word, vecs[i].exp);
            chk($sformatf("vec%0d_addr", i), a_out_addr, exp_addr);
            pop_one();
            chk($sformatf("vec%0d_count", i), {16'b0, a_word_count}, {16'b0, exp_cnt});
        end

        // Backpressure: three descriptors, out_ready low
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
        tick();
        chk("bp_ready1", {31'b0, a_in_ready}, 32'd1);
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd2);
        tick();
        chk("bp_ready2", {31'b0, a_in_ready}, 32'd0);
        chk("bp_head0", a_out_word, 32'h0010_0093);
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd3);
        tick();
        chk("bp_ready3", {31'b0, a_in_ready}, 32'd0);
        chk("bp_head_stable", a_out_word, 32'h0010_0093);
        chk("bp_addr_stable", a_out_addr, exp_addr);
        out_ready = 1'b1;
        tick();
        chk("bp_word1", a_out_word, 32'h0020_0093);
        chk("bp_addr1", a_out_addr, exp_addr + 32'd4);
        tick();
        in_valid = 1'b0;
        chk("bp_word2", a_out_word, 32'h0030_0093);
        chk("bp_addr2", a_out_addr, exp_addr + 32'd8);
        tick();
        out_ready = 1'b0;
        exp_addr = exp_addr + 32'd12;
        exp_cnt  = exp_cnt + 16'd3;
        chk("bp_count", {16'b0, a_word_count}, {16'b0, exp_cnt});
        chk("bp_drained", {31'b0, a_out_valid}, 32'd0);

        // INVALID
        drive(INVALID, 5'd1, 5'd1, 5'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("inv_pulse", {31'b0, a_err_invalid}, 32'd1);
        chk("inv_no_word", {31'b0, a_out_valid}, 32'd0);
        tick();
        chk("inv_pulse_end", {31'b0, a_err_invalid}, 32'd0);

        // ADDI imm=4096
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd4096);
        tick();
        in_valid = 1'b0;
`ifdef INSTR_ENC_RANGE_CHK_EN
        chk("range_word", a_out_word, 32'h0000_0013);
        chk("range_pulse", {31'b0, a_err_range}, 32'd1);
`else
        chk("range_word", a_out_word, 32'h0000_0093);
        chk("range_pulse", {31'b0, a_err_range}, 32'd0);
`endif
        chk("range_valid", {31'b0, a_out_valid}, 32'd1);
        pop_one();
        chk("range_pulse_end", {31'b0, a_err_range}, 32'd0);

        // Flush during a push: descriptor discarded, state cleared
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'b0, a_out_valid}, 32'd0);
        chk("flush_addr", a_out_addr, 32'h100);
        chk("flush_count", {16'b0, a_word_count}, 32'd0);
        chk("flush_w_addr", {28'b0, w_out_addr}, 32'hC);
        tick();
        chk("flush_still_empty", {31'b0, a_out_valid}, 32'd0);

        // Address wrap on the 4-bit instance: 0xC then 0x0
        out_ready = 1'b1;
        drive(ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        drive(SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        chk("wrap_addr0", {28'b0, w_out_addr}, 32'hC);
        chk("wrap_word0", w_out_word, 32'h0020_81B3);
        tick();
        in_valid = 1'b0;
        chk("wrap_addr1", {28'b0, w_out_addr}, 32'h0);
        chk("wrap_word1", w_out_word, 32'h4020_81B3);
        tick();
        out_ready = 1'b0;
        chk("wrap_count", {16'b0, w_word_count}, 32'd2);
        chk("wrap_addr2", {28'b0, w_out_addr}, 32'h4);

        // Asynchronous reset mid-stream
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        chk("arst_pre_valid", {31'b0, a_out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, a_out_valid}, 32'd0);
        chk("arst_addr", a_out_addr, 32'h100);
        chk("arst_count", {16'b0, a_word_count}, 32'd0);
        chk("arst_w_valid", {31'b0, w_out_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
